// File: rtl/xgmii_pktgen_if.sv
// xgmii_pktgen_if
// Bundles the burst control inputs, the XGMII TX word and the status
// outputs of one frame generator.
//   start, stop           : burst control (one-cycle request / level)
//   frame_count           : frames per burst, 0 = run until stop
//   dst_mac, src_mac      : addresses written into every frame header
//   xgmii_txd, xgmii_txc  : 64-bit XGMII TX data and per-lane control
//   busy, done            : burst in progress / one-cycle end-of-burst pulse
//   frames_sent           : frames completed in the current or last burst
// master = the generator itself, slave = whoever controls it and consumes
// the XGMII stream.
interface xgmii_pktgen_if;
    logic        start;
    logic        stop;
    logic [15:0] frame_count;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        busy;
    logic        done;
    logic [31:0] frames_sent;

    modport master (
        input  start, stop, frame_count, dst_mac, src_mac,
        output xgmii_txd, xgmii_txc, busy, done, frames_sent
    );

    modport slave (
        output start, stop, frame_count, dst_mac, src_mac,
        input  xgmii_txd, xgmii_txc, busy, done, frames_sent
    );
endinterface

// File: rtl/xgmii_pktgen.sv
// xgmii_pktgen
// XGMII 64-bit Ethernet test-frame generator. Emits bursts of frames, each
// laid out as PRE word, FRAME_LEN/8 DATA words, TERM word, IFG_WORDS idles.
// Frames carry DA, SA, ETHERTYPE, a 32-bit sequence number, an incrementing
// byte payload and a CRC-32 FCS.
// Ports:
//   clk156  : XGMII clock, only clock
//   sys_rst : synchronous active-high reset
//   bus     : control, XGMII TX word and status (see xgmii_pktgen_if)
// All outputs are registered: every value is computed for the state being
// entered (state_next) and loaded on the edge.
module xgmii_pktgen #(
    parameter int          FRAME_LEN = 64,
    parameter int          IFG_WORDS = 1,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic           clk156,
    input  logic           sys_rst,
    xgmii_pktgen_if.master bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_TERM, ST_GAP} state_t;

    localparam logic [63:0] IDLE_TXD = 64'h0707070707070707;
    localparam logic [63:0] PRE_TXD  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_TXD = 64'h07070707070707FD;
    localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN / 8 - 1);
    localparam logic [7:0]  LAST_GAP = 8'(IFG_WORDS - 1);

    state_t      state_reg, state_next;
    logic [7:0]  word_idx_reg, word_idx_next;
    logic [7:0]  gap_cnt_reg, gap_cnt_next;
    logic [31:0] crc_reg, crc_next;
    logic [31:0] seq_reg, seq_next;
    logic [31:0] frames_sent_reg, frames_sent_next;
    logic [15:0] frame_count_reg, frame_count_next;
    logic [47:0] dst_mac_reg, dst_mac_next;
    logic [47:0] src_mac_reg, src_mac_next;
    logic        stop_seen_reg, stop_seen_next;
    logic [63:0] txd_reg, txd_next;
    logic [7:0]  txc_reg, txc_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        burst_end;

    logic [7:0]  hdr_byte [18];
    logic [63:0] data_word;
    logic [31:0] crc_word;
    logic [31:0] fcs;

    // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_step64(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++)
            r = crc_byte(r, d[8*k +: 8]);
        return r;
    endfunction

    // Final word: only lanes 0..3 are CRC-covered, lanes 4..7 carry the FCS.
    function automatic logic [31:0] crc_step32(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 4; k++)
            r = crc_byte(r, d[8*k +: 8]);
        return r;
    endfunction

    // Header bytes 0..17 in wire order.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            hdr_byte[i]     = dst_mac_reg[8*(5-i) +: 8];
            hdr_byte[6 + i] = src_mac_reg[8*(5-i) +: 8];
        end
        hdr_byte[12] = ETHERTYPE[15:8];
        hdr_byte[13] = ETHERTYPE[7:0];
        for (int i = 0; i < 4; i++)
            hdr_byte[14 + i] = seq_reg[8*(3-i) +: 8];
    end

    // Byte offset of each lane in the word about to be emitted; the payload
    // byte is simply the low 8 bits of its own offset.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [10:0] b;
            assign b = {word_idx_next, 3'(gi)};
            assign data_word[8*gi +: 8] = (b < 11'd18) ? hdr_byte[b[4:0]] : b[7:0];
        end
    endgenerate

    assign crc_word  = crc_step64(crc_reg, data_word);
    assign fcs       = ~crc_step32(crc_reg, data_word[31:0]);
    assign burst_end = stop_seen_reg || bus.stop ||
                       ((frame_count_reg != 16'h0) &&
                        (frames_sent_reg == {16'h0, frame_count_reg}));

    // Next-state and counter logic.
    always_comb begin
        state_next       = state_reg;
        word_idx_next    = word_idx_reg;
        gap_cnt_next     = gap_cnt_reg;
        seq_next         = seq_reg;
        frames_sent_next = frames_sent_reg;
        frame_count_next = frame_count_reg;
        dst_mac_next     = dst_mac_reg;
        src_mac_next     = src_mac_reg;
        done_next        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next       = ST_PRE;
                    dst_mac_next     = bus.dst_mac;
                    src_mac_next     = bus.src_mac;
                    frame_count_next = bus.frame_count;
                    seq_next         = 32'h0;
                    frames_sent_next = 32'h0;
                end
            end
            ST_PRE: begin
                state_next    = ST_DATA;
                word_idx_next = 8'h0;
            end
            ST_DATA: begin
                if (word_idx_reg == LAST_IDX) begin
                    state_next       = ST_TERM;
                    frames_sent_next = frames_sent_reg + 32'h1;
                    seq_next         = seq_reg + 32'h1;
                end else begin
                    word_idx_next = word_idx_reg + 8'h1;
                end
            end
            ST_TERM: begin
                state_next   = ST_GAP;
                gap_cnt_next = 8'h0;
            end
            ST_GAP: begin
                if (gap_cnt_reg == LAST_GAP) begin
                    if (burst_end) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_PRE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'h1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output word, CRC accumulation and status for the state being entered.
    always_comb begin
        txd_next       = IDLE_TXD;
        txc_next       = 8'hFF;
        crc_next       = crc_reg;
        busy_next      = (state_next != ST_IDLE);
        // A stop seen at any point since the last PRE ends the burst later.
        stop_seen_next = (state_next == ST_PRE) ? 1'b0 : (stop_seen_reg | bus.stop);

        case (state_next)
            ST_PRE: begin
                txd_next = PRE_TXD;
                txc_next = 8'h01;
                crc_next = 32'hFFFFFFFF;
            end
            ST_DATA: begin
                txc_next = 8'h00;
                if (word_idx_next == LAST_IDX) begin
                    txd_next = {fcs, data_word[31:0]};
                end else begin
                    txd_next = data_word;
                    crc_next = crc_word;
                end
            end
            ST_TERM: txd_next = TERM_TXD;
            default: ;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state_reg       <= ST_IDLE;
            word_idx_reg    <= 8'h0;
            gap_cnt_reg     <= 8'h0;
            crc_reg         <= 32'hFFFFFFFF;
            seq_reg         <= 32'h0;
            frames_sent_reg <= 32'h0;
            frame_count_reg <= 16'h0;
            dst_mac_reg     <= 48'h0;
            src_mac_reg     <= 48'h0;
            stop_seen_reg   <= 1'b0;
            txd_reg         <= IDLE_TXD;
            txc_reg         <= 8'hFF;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            word_idx_reg    <= word_idx_next;
            gap_cnt_reg     <= gap_cnt_next;
            crc_reg         <= crc_next;
            seq_reg         <= seq_next;
            frames_sent_reg <= frames_sent_next;
            frame_count_reg <= frame_count_next;
            dst_mac_reg     <= dst_mac_next;
            src_mac_reg     <= src_mac_next;
            stop_seen_reg   <= stop_seen_next;
            txd_reg         <= txd_next;
            txc_reg         <= txc_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    assign bus.xgmii_txd   = txd_reg;
    assign bus.xgmii_txc   = txc_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.frames_sent = frames_sent_reg;
endmodule

// File: tb/tb_xgmii_pktgen.sv
// tb_xgmii_pktgen
// Two generators: dut_a (64-byte frames, 1 idle) and dut_b (1520-byte
// frames, 5 idles). Expected words for a whole burst are pushed into a
// per-DUT queue, tagged with the cycle they must appear in; a negedge
// monitor pops and compares, and expects the idle word whenever nothing
// is scheduled.
module tb_xgmii_pktgen;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W = 64'h07070707070707FD;

    typedef struct {
        int unsigned cyc;
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        busy;
        logic        done;
    } exp_t;

    logic        clk156 = 1'b0;
    logic        sys_rst;
    logic        mon_en = 1'b0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb_a[$];
    exp_t        sb_b[$];

    xgmii_pktgen_if bus_a ();
    xgmii_pktgen_if bus_b ();

    xgmii_pktgen #(.FRAME_LEN(64), .IFG_WORDS(1)) dut_a (
        .clk156  (clk156),
        .sys_rst (sys_rst),
        .bus     (bus_a)
    );

    xgmii_pktgen #(.FRAME_LEN(1520), .IFG_WORDS(5)) dut_b (
        .clk156  (clk156),
        .sys_rst (sys_rst),
        .bus     (bus_b)
    );

    always #5 clk156 = ~clk156;
    always @(posedge clk156) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [79:0] pack(input logic [63:0] d, input logic [7:0] c,
                                         input logic b, input logic dn);
        return {6'd0, c, d, b, dn};
    endfunction

    task automatic add(input int u, input int unsigned c, input logic [63:0] d,
                       input logic [7:0] k, input logic b, input logic dn);
        exp_t e;
        e.cyc = c; e.txd = d; e.txc = k; e.busy = b; e.done = dn;
        if (u == 0) sb_a.push_back(e);
        else        sb_b.push_back(e);
    endtask

    // Expected words of a burst of nfr frames, seq counting from 0, PRE at
    // cycle base. The FCS is computed MSB-first on bit-reversed bytes.
    task automatic push_burst(input int u, input int unsigned base,
                              input logic [47:0] dst, input logic [47:0] src,
                              input int nfr, input int flen, input int ifg,
                              output int unsigned done_cyc);
        logic [7:0]  fb [1520];
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [31:0] sq;
        logic [7:0]  rb;
        logic [63:0] w;
        int unsigned c;
        c = base;
        for (int f = 0; f < nfr; f++) begin
            sq = 32'(f);
            for (int i = 0; i < 6; i++) begin
                fb[i]     = dst[8*(5-i) +: 8];
                fb[6 + i] = src[8*(5-i) +: 8];
            end
            fb[12] = 8'h88;
            fb[13] = 8'hB5;
            for (int i = 0; i < 4; i++) fb[14 + i] = sq[8*(3-i) +: 8];
            for (int i = 18; i < flen - 4; i++) fb[i] = 8'(i);
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < flen - 4; i++) begin
                for (int k = 0; k < 8; k++) rb[k] = fb[i][7-k];
                crc = crc ^ {rb, 24'h0};
                for (int k = 0; k < 8; k++)
                    crc = crc[31] ? ((crc << 1) ^ 32'h04C11DB7) : (crc << 1);
            end
            crc = ~crc;
            for (int k = 0; k < 32; k++) fcs[k] = crc[31-k];
            for (int j = 0; j < 4; j++) fb[flen - 4 + j] = fcs[8*j +: 8];

            add(u, c, PRE_W, 8'h01, 1'b1, 1'b0); c++;
            for (int wd = 0; wd < flen / 8; wd++) begin
                for (int l = 0; l < 8; l++) w[8*l +: 8] = fb[8*wd + l];
                add(u, c, w, 8'h00, 1'b1, 1'b0); c++;
            end
            add(u, c, TERM_W, 8'hFF, 1'b1, 1'b0); c++;
            for (int g = 0; g < ifg; g++) begin
                add(u, c, IDLE_W, 8'hFF, 1'b1, 1'b0); c++;
            end
        end
        add(u, c, IDLE_W, 8'hFF, 1'b0, 1'b1);
        done_cyc = c;
    endtask

    always @(negedge clk156) begin
        if (mon_en) begin
            exp_t e;
            if (sb_a.size() > 0 && sb_a[0].cyc == cyc) e = sb_a.pop_front();
            else e = '{cyc, IDLE_W, 8'hFF, 1'b0, 1'b0};
            chk("a_word", pack(bus_a.xgmii_txd, bus_a.xgmii_txc, bus_a.busy, bus_a.done),
                pack(e.txd, e.txc, e.busy, e.done));
            if (e.txc == 8'hFF && e.txd[7:0] == 8'hFD)
                $display("a: frame terminated at cyc %0d", cyc);
        end
    end

    always @(negedge clk156) begin
        if (mon_en) begin
            exp_t e;
            if (sb_b.size() > 0 && sb_b[0].cyc == cyc) e = sb_b.pop_front();
            else e = '{cyc, IDLE_W, 8'hFF, 1'b0, 1'b0};
            chk("b_word", pack(bus_b.xgmii_txd, bus_b.xgmii_txc, bus_b.busy, bus_b.done),
                pack(e.txd, e.txc, e.busy, e.done));
            if (e.txc == 8'hFF && e.txd[7:0] == 8'hFD)
                $display("b: frame terminated at cyc %0d", cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk156);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) step(1);
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((sb_a.size() > 0 || sb_b.size() > 0) && n < maxc) begin
            step(1);
            n++;
        end
        chk("drain", 80'(sb_a.size() + sb_b.size()), 80'(0));
    endtask

    task automatic start_a(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] fc);
        bus_a.dst_mac     = dst;
        bus_a.src_mac     = src;
        bus_a.frame_count = fc;
        bus_a.start       = 1'b1;
    endtask

    initial begin
        int unsigned base;
        int unsigned dcyc;

        sys_rst = 1'b1;
        bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.frame_count = 16'h0;
        bus_a.dst_mac = 48'h0; bus_a.src_mac = 48'h0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.frame_count = 16'h0;
        bus_b.dst_mac = 48'h0; bus_b.src_mac = 48'h0;
        step(3);
        chk("rst_word", pack(bus_a.xgmii_txd, bus_a.xgmii_txc, bus_a.busy, bus_a.done),
            pack(IDLE_W, 8'hFF, 1'b0, 1'b0));
        chk("rst_frames", 80'(bus_a.frames_sent), 80'(0));
        sys_rst = 1'b0;
        mon_en = 1'b1;
        step(2);

        // single frame
        $display("burst: single frame");
        start_a(48'hFFFFFFFFFFFF, 48'h001122334455, 16'd1);
        push_burst(0, cyc + 1, 48'hFFFFFFFFFFFF, 48'h001122334455, 1, 64, 1, dcyc);
        step(1);
        bus_a.start = 1'b0;
        wait_drain(100);
        chk("single_frames", 80'(bus_a.frames_sent), 80'(1));

        // three frames, ignored start mid-frame, restart in the done cycle
        $display("burst: three frames");
        start_a(48'h0A0B0C0D0E0F, 48'h102030405060, 16'd3);
        base = cyc + 1;
        push_burst(0, base, 48'h0A0B0C0D0E0F, 48'h102030405060, 3, 64, 1, dcyc);
        step(1);
        bus_a.start = 1'b0;
        wait_cyc(base + 14);
        start_a(48'h111111111111, 48'h222222222222, 16'd9);
        step(1);
        bus_a.start = 1'b0;
        wait_cyc(dcyc);
        chk("three_frames", 80'(bus_a.frames_sent), 80'(3));
        chk("three_done", 80'(bus_a.done), 80'(1));
        $display("burst: restart in done cycle");
        start_a(48'h665544332211, 48'hA1A2A3A4A5A6, 16'd2);
        push_burst(0, cyc + 1, 48'h665544332211, 48'hA1A2A3A4A5A6, 2, 64, 1, dcyc);
        step(1);
        bus_a.start = 1'b0;
        wait_drain(100);
        chk("restart_frames", 80'(bus_a.frames_sent), 80'(2));

        // continuous mode, stop in the middle of frame 4
        $display("burst: continuous with stop");
        start_a(48'h020000000001, 48'h020000000002, 16'd0);
        base = cyc + 1;
        push_burst(0, base, 48'h020000000001, 48'h020000000002, 4, 64, 1, dcyc);
        step(1);
        bus_a.start = 1'b0;
        wait_cyc(base + 37);
        bus_a.stop = 1'b1;
        step(1);
        bus_a.stop = 1'b0;
        wait_drain(100);
        chk("stop_frames", 80'(bus_a.frames_sent), 80'(4));

        // long frames on dut_b
        $display("burst: 1520-byte frames");
        bus_b.dst_mac = 48'hDEADBEEF0001;
        bus_b.src_mac = 48'h00AABBCCDDEE;
        bus_b.frame_count = 16'd2;
        bus_b.start = 1'b1;
        push_burst(1, cyc + 1, 48'hDEADBEEF0001, 48'h00AABBCCDDEE, 2, 1520, 5, dcyc);
        step(1);
        bus_b.start = 1'b0;
        wait_drain(600);
        chk("long_frames", 80'(bus_b.frames_sent), 80'(2));

        // reset in the middle of a frame, then a clean frame
        $display("burst: reset mid-frame");
        start_a(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'd1);
        base = cyc + 1;
        push_burst(0, base, 48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 1, 64, 1, dcyc);
        step(1);
        bus_a.start = 1'b0;
        wait_cyc(base + 4);
        sys_rst = 1'b1;
        while (sb_a.size() > 0 && sb_a[$].cyc > cyc) void'(sb_a.pop_back());
        step(1);
        chk("rst_mid_busy", 80'(bus_a.busy), 80'(0));
        chk("rst_mid_frames", 80'(bus_a.frames_sent), 80'(0));
        sys_rst = 1'b0;
        step(1);
        start_a(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'd1);
        push_burst(0, cyc + 1, 48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 1, 64, 1, dcyc);
        step(1);
        bus_a.start = 1'b0;
        wait_drain(100);
        chk("post_rst_frames", 80'(bus_a.frames_sent), 80'(1));
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
